// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// slave: the sequencer. master: the command source, ALU and response consumer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_sel;
  logic             cmd_use_acc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_zero;
  logic             rsp_err;
  logic [WIDTH-1:0] acc_out;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc, alu_result, alu_cout, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_cout, rsp_zero,
           rsp_err, acc_out
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc, alu_result, alu_cout, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_cout, rsp_zero,
           rsp_err, acc_out
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command front end for a combinational 8-bit ALU: registers
// operands, holds them for a settle window, captures the result with status flags.
module alu_cmd_sequencer #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      SETTLE_CYCLES = 1,
  parameter logic [WIDTH-1:0] ACC_RESET     = '0
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             cmd_ready_q;
  logic             err_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_sel_q;
  logic [WIDTH-1:0] acc_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_cout_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  logic cmd_unsupported;
  assign cmd_unsupported = bus.cmd_sel inside {3'b001, 3'b010, 3'b011};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b0;
      err_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      acc_q        <= ACC_RESET;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // ready rises one edge after reset release, then drops on accept
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            alu_a_q     <= bus.cmd_a;
            alu_b_q     <= bus.cmd_use_acc ? acc_q : bus.cmd_b;
            alu_sel_q   <= bus.cmd_sel;
            err_q       <= cmd_unsupported;
            cnt_q       <= 4'(SETTLE_CYCLES);
            cmd_ready_q <= 1'b0;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            rsp_result_q <= err_q ? '0 : bus.alu_result;
            rsp_cout_q   <= (alu_sel_q == 3'b000) && !err_q && bus.alu_cout;
            rsp_zero_q   <= !err_q && (bus.alu_result == '0);
            rsp_err_q    <= err_q;
            rsp_valid_q  <= 1'b1;
            if (!err_q) begin
              acc_q <= bus.alu_result;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.acc_out    = acc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a 1-cycle-settle instance for directed and random
// ops against an arithmetic reference, and a 3-cycle-settle instance for mid-op reset.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int unsigned W        = 8;
  localparam logic [7:0]  ACC_RST3 = 8'h5A;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  logic [7:0] acc_m;

  alu_cmd_sequencer_if #(.WIDTH(W)) if1 ();
  alu_cmd_sequencer_if #(.WIDTH(W)) if3 ();

  alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1), .ACC_RESET(8'h00)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3), .ACC_RESET(ACC_RST3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(if3)
  );

  always #5 clk = ~clk;

  // ALU stand-in; non-ADD ops and unsupported codes return carry=1 so masking is visible
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] sel);
    case (sel)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b100:  return {1'b1, a & b};
      3'b101:  return {1'b1, a | b};
      3'b110:  return {1'b1, a ^ b};
      3'b111:  return {1'b1, ~a};
      default: return {1'b1, 8'hA5};
    endcase
  endfunction

  always_comb {if1.alu_cout, if1.alu_result} = alu_f(if1.alu_a, if1.alu_b, if1.alu_sel);
  always_comb {if3.alu_cout, if3.alu_result} = alu_f(if3.alu_a, if3.alu_b, if3.alu_sel);

  // Expected response from the operation table using integer arithmetic
  task automatic ref_op(input int unsigned a, input int unsigned b, input int unsigned sel,
                        output logic [7:0] res, output logic cout, output logic zero,
                        output logic err);
    int unsigned r;
    err  = (sel >= 1 && sel <= 3);
    cout = 1'b0;
    r    = 0;
    case (sel)
      0: begin r = (a + b) % 256; cout = (a + b) >= 256; end
      4: for (int unsigned k = 0; k < 8; k++) if (a[k] && b[k]) r += (1 << k);
      5: for (int unsigned k = 0; k < 8; k++) if (a[k] || b[k]) r += (1 << k);
      6: for (int unsigned k = 0; k < 8; k++) if (a[k] != b[k]) r += (1 << k);
      7: r = 255 - a;
      default: r = 0;
    endcase
    res  = 8'(r);
    zero = !err && (r == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                       input logic use_acc, input int unsigned hold);
    logic [7:0] bexp, er;
    logic       ec, ez, ee;
    int         m;
    bexp = use_acc ? acc_m : b;
    ref_op(a, bexp, sel, er, ec, ez, ee);
    m = 0;
    while (if1.cmd_ready !== 1'b1 && m < 20) begin @(negedge clk); m++; end
    chk("cmd_ready_wait", if1.cmd_ready, 1);
    if1.cmd_a = a; if1.cmd_b = b; if1.cmd_sel = sel; if1.cmd_use_acc = use_acc;
    if1.cmd_valid = 1'b1;
    @(negedge clk);
    if1.cmd_valid   = 1'b0;
    if1.cmd_a       = 8'($urandom);
    if1.cmd_b       = 8'($urandom);
    if1.cmd_sel     = 3'($urandom);
    if1.cmd_use_acc = 1'($urandom);
    chk("ready_low_after_accept", if1.cmd_ready, 0);
    chk("alu_ops", {if1.alu_sel, if1.alu_b, if1.alu_a}, {sel, bexp, a});
    m = 0;
    while (if1.rsp_valid !== 1'b1 && m < 20) begin @(negedge clk); m++; end
    chk("rsp_latency", m, 1);
    chk("rsp_result", if1.rsp_result, er);
    chk("rsp_flags", {if1.rsp_cout, if1.rsp_zero, if1.rsp_err}, {ec, ez, ee});
    chk("acc_out", if1.acc_out, ee ? acc_m : er);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {if1.rsp_valid, if1.rsp_cout, if1.rsp_zero, if1.rsp_err,
                       if1.cmd_ready, if1.rsp_result}, {1'b1, ec, ez, ee, 1'b0, er});
    end
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    if1.rsp_ready = 1'b0;
    chk("rsp_valid_drop", if1.rsp_valid, 0);
    chk("ready_after_rsp", if1.cmd_ready, 1);
    chk("alu_held_idle", {if1.alu_sel, if1.alu_b, if1.alu_a}, {sel, bexp, a});
    if (!ee) acc_m = er;
  endtask

  initial begin
    {if1.cmd_valid, if1.cmd_a, if1.cmd_b, if1.cmd_sel, if1.cmd_use_acc, if1.rsp_ready} = '0;
    {if3.cmd_valid, if3.cmd_a, if3.cmd_b, if3.cmd_sel, if3.cmd_use_acc, if3.rsp_ready} = '0;
    rst  = 1'b1;
    rst3 = 1'b1;
    acc_m = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst1_state", {if1.cmd_ready, if1.rsp_valid, if1.rsp_result, if1.alu_a, if1.alu_sel},
        '0);
    chk("rst1_acc", if1.acc_out, 8'h00);
    chk("rst3_acc", if3.acc_out, ACC_RST3);
    chk("rst3_ready", if3.cmd_ready, 0);
    rst  = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk("ready_after_rst1", if1.cmd_ready, 1);
    chk("ready_after_rst3", if3.cmd_ready, 1);

    do_op(8'd13, 8'd3, 3'b000, 1'b0, 0);
    chk("t1_acc16", if1.acc_out, 8'd16);
    do_op(8'd255, 8'd1, 3'b000, 1'b0, 1);
    do_op(8'hAA, 8'hCC, 3'b100, 1'b0, 0);
    do_op(8'hAA, 8'hCC, 3'b101, 1'b0, 0);
    do_op(8'hAA, 8'hCC, 3'b110, 1'b0, 2);
    do_op(8'hAA, 8'hCC, 3'b111, 1'b0, 0);
    do_op(8'h10, 8'h00, 3'b000, 1'b0, 0);
    do_op(8'h05, 8'hE7, 3'b000, 1'b1, 0);
    chk("t4_acc15", if1.acc_out, 8'h15);
    do_op(8'h11, 8'h22, 3'b010, 1'b0, 5);
    chk("t5_acc_kept", if1.acc_out, 8'h15);

    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3));
    end

    // 3-cycle settle: one full op, then reset during the second settle cycle
    if3.cmd_a = 8'h20; if3.cmd_b = 8'h01; if3.cmd_sel = 3'b000; if3.cmd_use_acc = 1'b0;
    if3.cmd_valid = 1'b1;
    @(negedge clk);
    if3.cmd_valid = 1'b0;
    n = 0;
    while (if3.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("lat3", n, 3);
    chk("r3_result", if3.rsp_result, 8'h21);
    chk("r3_acc", if3.acc_out, 8'h21);
    if3.rsp_ready = 1'b1;
    @(negedge clk);
    if3.rsp_ready = 1'b0;
    chk("r3_ready_back", if3.cmd_ready, 1);
    if3.cmd_a = 8'h30; if3.cmd_b = 8'h02; if3.cmd_use_acc = 1'b1;
    if3.cmd_valid = 1'b1;
    @(negedge clk);
    if3.cmd_valid = 1'b0;
    chk("r3_alu_b_acc", if3.alu_b, 8'h21);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("r3_rst_state", {if3.rsp_valid, if3.cmd_ready, if3.alu_a, if3.alu_b}, '0);
    chk("r3_rst_acc", if3.acc_out, ACC_RST3);
    @(negedge clk);
    chk("r3_ready_after_rst", if3.cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("r3_no_rsp", {if3.rsp_valid, if3.acc_out}, {1'b0, ACC_RST3});
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
